// File: rtl/snn_pkg.sv
// Shared definitions for the spike-rate decoder slice.
// Holds the decoder FSM state type and the default window/output widths
// used by the interface and the top module.
package snn_pkg;

  localparam int unsigned DEF_WIN_LOG2 = 8;
  localparam int unsigned DEF_OUT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_TRACK      = 2'd2
  } state_e;

endpackage : snn_pkg

// File: rtl/spike_rate_decoder_if.sv
// Signal bundle between a spiking neuron source and the rate decoder.
//   spike    : spike level from the neuron (may be held high)
//   enable   : decoding active when high
//   rate     : spike count of the last completed window
//   isi      : last measured inter-spike interval, in cycles
//   valid    : one-cycle pulse when rate updates
//   overflow : last completed window saturated the spike count
// master = neuron/host side, slave = decoder side.
interface spike_rate_decoder_if
  import snn_pkg::*;
#(
  parameter int unsigned OUT_W = DEF_OUT_W
);

  logic             spike;
  logic             enable;
  logic [OUT_W-1:0] rate;
  logic [OUT_W-1:0] isi;
  logic             valid;
  logic             overflow;

  modport master (
    output spike,
    output enable,
    input  rate,
    input  isi,
    input  valid,
    input  overflow
  );

  modport slave (
    input  spike,
    input  enable,
    output rate,
    output isi,
    output valid,
    output overflow
  );

endinterface : spike_rate_decoder_if

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : increment by one unless already at all-ones
//   count_o    : current count
//   sat_o      : count is at all-ones
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count_o,
  output logic         sat_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign sat_o   = (count_q == '1);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : sat_counter

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising spike edges over fixed windows of
// 2^WIN_LOG2 cycles and measures the interval between consecutive events.
//   clk     : clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of spike_rate_decoder_if
//             (spike/enable in; rate/isi/valid/overflow out, all registered)
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
  parameter int unsigned OUT_W    = DEF_OUT_W
) (
  input logic                 clk,
  input logic                 reset_n,
  spike_rate_decoder_if.slave bus
);

  state_e              state_q, state_d;
  logic                spike_q, spike_d;
  logic [WIN_LOG2-1:0] win_q,   win_d;
  logic [OUT_W-1:0]    rate_q,  rate_d;
  logic [OUT_W-1:0]    isi_q,   isi_d;
  logic                valid_q, valid_d;
  logic                ovf_q,   ovf_d;

  logic             evt;
  logic             active;
  logic             in_track;
  logic             win_last;

  logic             spk_clr, spk_inc, spk_sat;
  logic [OUT_W-1:0] spk_cnt, spk_total;
  logic             int_clr, int_inc, int_sat;
  logic [OUT_W-1:0] int_cnt, int_plus;

  // Counting only happens while enabled in a non-idle state; a cycle with
  // enable low already heads to IDLE, so it neither counts nor closes a window.
  assign evt      = bus.spike & ~spike_q;
  assign active   = bus.enable && (state_q != ST_IDLE);
  assign in_track = bus.enable && (state_q == ST_TRACK);
  assign win_last = active && (win_q == '1);

  // Spike count reported at window end includes an event on the final cycle.
  assign spk_inc   = active & evt;
  assign spk_clr   = ~active | win_last;
  assign spk_total = spk_sat ? spk_cnt : spk_cnt + OUT_W'(evt);

  // Interval counter runs every TRACK cycle and restarts on each event;
  // the measured interval is the count including the event cycle itself.
  assign int_inc  = in_track;
  assign int_clr  = ~in_track | evt;
  assign int_plus = int_sat ? int_cnt : int_cnt + 1'b1;

  sat_counter #(.W(OUT_W)) u_spk_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr     (spk_clr),
    .inc     (spk_inc),
    .count_o (spk_cnt),
    .sat_o   (spk_sat)
  );

  sat_counter #(.W(OUT_W)) u_int_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr     (int_clr),
    .inc     (int_inc),
    .count_o (int_cnt),
    .sat_o   (int_sat)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST: begin
        if (!bus.enable) state_d = ST_IDLE;
        else if (evt)    state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (!bus.enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spike_d = bus.spike;
    win_d   = active ? win_q + 1'b1 : '0;
    rate_d  = rate_q;
    isi_d   = isi_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    if (win_last) begin
      rate_d  = spk_total;
      ovf_d   = (spk_total == '1);
      valid_d = 1'b1;
    end

    // The first event after enabling only arms tracking (WAIT_FIRST).
    if (in_track && evt) begin
      isi_d = int_plus;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      spike_q <= 1'b0;
      win_q   <= '0;
      rate_q  <= '0;
      isi_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      spike_q <= spike_d;
      win_q   <= win_d;
      rate_q  <= rate_d;
      isi_q   <= isi_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.rate     = rate_q;
  assign bus.isi      = isi_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;

endmodule : spike_rate_decoder

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

  localparam int WIN  = 16;
  localparam int MAX8 = 255;
  localparam int MAX3 = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spike = 1'b0;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  spike_rate_decoder_if #(.OUT_W(8)) if8 ();
  spike_rate_decoder_if #(.OUT_W(3)) if3 ();

  assign if8.spike  = spike;
  assign if8.enable = enable;
  assign if3.spike  = spike;
  assign if3.enable = enable;

  spike_rate_decoder #(.WIN_LOG2(4), .OUT_W(8)) u_dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if8)
  );

  spike_rate_decoder #(.WIN_LOG2(4), .OUT_W(3)) u_dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from event times: rate = events in window (capped),
  // isi = time between consecutive events (capped).
  typedef struct {
    int rate;
    int isi;
    int ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];

  bit     m_on, m_first, m_prev;
  int     m_pos, m_events, m_isi8, m_isi3;
  longint m_cyc, m_last;

  function automatic int cap(input longint v, input int m);
    return (v > m) ? m : int'(v);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit   ev;
    exp_t e;
    if (!reset_n) begin
      m_on = 0; m_first = 0; m_prev = 0;
      m_pos = 0; m_events = 0; m_isi8 = 0; m_isi3 = 0;
      m_cyc = 0; m_last = 0;
      q8.delete();
      q3.delete();
    end else begin
      m_cyc++;
      ev = spike && !m_prev;
      m_prev = spike;
      if (!m_on) begin
        if (enable) begin
          m_on = 1; m_pos = 0; m_events = 0; m_first = 0;
        end
      end else if (!enable) begin
        m_on = 0;
      end else begin
        if (ev) begin
          m_events++;
          if (m_first) begin
            m_isi8 = cap(m_cyc - m_last, MAX8);
            m_isi3 = cap(m_cyc - m_last, MAX3);
          end
          m_first = 1;
          m_last  = m_cyc;
        end
        if (m_pos == WIN - 1) begin
          e.rate = cap(m_events, MAX8); e.isi = m_isi8; e.ovf = (m_events >= MAX8);
          q8.push_back(e);
          e.rate = cap(m_events, MAX3); e.isi = m_isi3; e.ovf = (m_events >= MAX3);
          q3.push_back(e);
          m_events = 0;
        end
        m_pos = (m_pos + 1) % WIN;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (if8.valid) begin
        if (q8.size() == 0) check("dut8_spurious_valid", 1, 0);
        else begin
          e = q8.pop_front();
          check("dut8_rate", int'(if8.rate), e.rate);
          check("dut8_isi", int'(if8.isi), e.isi);
          check("dut8_overflow", int'(if8.overflow), e.ovf);
        end
      end else if (q8.size() > 0) begin
        check("dut8_valid_latency", 0, 1);
        void'(q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (if3.valid) begin
        if (q3.size() == 0) check("dut3_spurious_valid", 1, 0);
        else begin
          e = q3.pop_front();
          check("dut3_rate", int'(if3.rate), e.rate);
          check("dut3_isi", int'(if3.isi), e.isi);
          check("dut3_overflow", int'(if3.overflow), e.ovf);
        end
      end else if (q3.size() > 0) begin
        check("dut3_valid_latency", 0, 1);
        void'(q3.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit e);
    spike  = s;
    enable = e;
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rate8"}, int'(if8.rate), 0);
    check({tag, "_isi8"}, int'(if8.isi), 0);
    check({tag, "_valid8"}, int'(if8.valid), 0);
    check({tag, "_ovf8"}, int'(if8.overflow), 0);
    check({tag, "_rate3"}, int'(if3.rate), 0);
    check({tag, "_valid3"}, int'(if3.valid), 0);
    check({tag, "_ovf3"}, int'(if3.overflow), 0);
  endtask

  initial begin
    @(posedge clk); #2;
    step(0, 0);
    step(0, 0);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #2;
    reset_n = 1'b1;
    step(0, 0);

    // Periodic one-cycle spikes every 4 cycles over several windows.
    for (int c = 0; c < 5 * WIN + 1; c++) step((c % 4) == 0, 1);

    // Spike held high for 10 cycles, then quiet.
    for (int c = 0; c < 10; c++) step(1, 1);
    for (int c = 0; c < 2 * WIN; c++) step(0, 1);

    // Spike toggling every cycle saturates the narrow instance.
    for (int c = 0; c < 3 * WIN; c++) step(c % 2, 1);

    // Enable dropped at window cycle 9 after 3 events, then 2 events.
    step(0, 0); step(0, 0);
    step(0, 1);
    for (int k = 0; k < 9; k++) step((k % 3) == 1, 1);
    step(0, 0); step(0, 0);
    step(0, 1);
    for (int k = 0; k < WIN; k++) step(k == 3 || k == 8, 1);

    // Event on the final window cycle, followed by an empty window.
    step(0, 0); step(0, 0);
    step(0, 1);
    for (int k = 0; k < 2 * WIN; k++) step(k == WIN - 1, 1);

    // Long gap between events saturates the interval.
    step(1, 1);
    for (int c = 0; c < 299; c++) step(0, 1);
    step(1, 1);
    for (int c = 0; c < 2 * WIN; c++) step(0, 1);

    // Random spikes with occasional enable drops.
    for (int c = 0; c < 700; c++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 99) >= 2);

    // Reset asserted mid-run.
    for (int c = 0; c < 21; c++) step((c % 3) == 0, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(1, 1);
    step(0, 0);
    reset_n = 1'b1;
    for (int c = 0; c < WIN; c++) begin
      step($urandom_range(0, 1), 0);
      @(negedge clk);
      check("post_reset_valid8", int'(if8.valid), 0);
      check("post_reset_valid3", int'(if3.valid), 0);
    end

    // Short run after reset, then drain.
    for (int c = 0; c < 2 * WIN + 2; c++) step((c % 5) == 0, 1);
    for (int c = 0; c < 4; c++) step(0, 0);
    check("drain_q8", q8.size(), 0);
    check("drain_q3", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spike_rate_decoder
